// File: rtl/bcd2binary_seq.sv
// bcd2binary_seq: sequential reverse double-dabble BCD-to-binary converter with start/busy/done handshake.
// Define BCD2BIN_FAST_EN for two shift/correct steps per clock (BIN_W must then be even).
module bcd2binary_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      binary
);
    localparam int BW = 4 * DIGITS;
    localparam int TW = BW + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);
`ifdef BCD2BIN_FAST_EN
    localparam int STEPS = 2;
`else
    localparam int STEPS = 1;
`endif
    localparam logic [CW-1:0] STEP_C = CW'(STEPS);
    localparam logic [CW-1:0] LAST_C = CW'(BIN_W - STEPS);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [BIN_W-1:0]  binary_q, binary_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [TW-1:0]     sh;

    function automatic logic [TW-1:0] step(input logic [TW-1:0] v);
        logic [TW-1:0] s;
        s = v >> 1;
        for (int k = 0; k < DIGITS; k++)
            s[BIN_W+4*k +: 4] = (s[BIN_W+4*k +: 4] >= 4'd8) ? s[BIN_W+4*k +: 4] - 4'd3 : s[BIN_W+4*k +: 4];
        return s;
    endfunction

    function automatic logic has_bad(input logic [BW-1:0] v);
        logic b;
        b = 1'b0;
        for (int k = 0; k < DIGITS; k++)
            b = b | (v[4*k +: 4] > 4'd9);
        return b;
    endfunction

    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        bin_d    = bin_q;
        binary_d = binary_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        sh       = {bcd_q, bin_q};
        for (int i = 0; i < STEPS; i++)
            sh = step(sh);
        case (state_q)
            IDLE: if (start) begin
                bcd_d   = bcd_in;
                bin_d   = '0;
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = SHIFT;
            end
            // The latched digits are validated on the first SHIFT edge, so errors finish after E1.
            SHIFT: if (cnt_q == '0 && has_bad(bcd_q)) begin
                err_d    = 1'b1;
                binary_d = '0;
                state_d  = DONE;
            end else begin
                {bcd_d, bin_d} = sh;
                cnt_d          = cnt_q + STEP_C;
                binary_d       = (cnt_q == LAST_C) ? sh[BIN_W-1:0] : binary_q;
                state_d        = (cnt_q == LAST_C) ? DONE : SHIFT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            bcd_q    <= '0;
            bin_q    <= '0;
            binary_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcd_q    <= bcd_d;
            bin_q    <= bin_d;
            binary_q <= binary_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign err    = err_q;
    assign binary = binary_q;
endmodule

// File: tb/tb_bcd2binary_seq.sv
// tb_bcd2binary_seq: directed bench for bcd2binary_seq with a result scoreboard popped on each done pulse.
module tb_bcd2binary_seq;
`ifdef BCD2BIN_FAST_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 14;
`endif
    typedef struct packed {
        logic [13:0] bin;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr, start;
    logic [15:0] bcd_in;
    logic        busy, done, err;
    logic [13:0] binary;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    bcd2binary_seq dut (
        .clk(clk), .clr(clr), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .err(err), .binary(binary)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) check("spurious_done", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("binary", 32'(binary), 32'(e.bin));
                check("err", 32'(err), 32'(e.err));
            end
        end
    end

    function automatic exp_t model(input logic [15:0] b);
        exp_t e;
        int v;
        logic [3:0] d;
        v = 0;
        e.err = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            d = b[4*k +: 4];
            if (d > 4'd9) e.err = 1'b1;
            v = v * 10 + int'(d);
        end
        e.bin = e.err ? 14'd0 : 14'(v);
        return e;
    endfunction

    task automatic wait_done(input int n0, input int lat, input string tag);
        int n;
        n = n0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (done !== 1'b1 && n < 60);
        check({tag, "_latency"}, 32'(n), 32'(lat));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic run(input logic [15:0] b, input string tag);
        exp_t e;
        e = model(b);
        sb.push_back(e);
        bcd_in = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bcd_in = 16'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_err_clr"}, 32'(err), 32'd0);
        wait_done(0, e.err ? 1 : LAT, tag);
    endtask

    initial begin
        int d0;
        clr = 1'b1; start = 1'b0; bcd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_binary", 32'(binary), 32'd0);
        clr = 1'b0;
        @(posedge clk);
        #1;
        run(16'h4571, "v4571");
        run(16'h9999, "v9999");
        run(16'h0000, "v0000");
        run(16'h12A4, "bad12A4");
        check("err_held", 32'(err), 32'd1);
        check("err_binary_held", 32'(binary), 32'd0);
        run(16'h0010, "v0010");
        run(16'h0987, "v0987");
        // Restart during conversion and input change after acceptance must not disturb the result.
        d0 = done_cnt;
        sb.push_back(model(16'h2023));
        bcd_in = 16'h2023; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1; bcd_in = 16'h1111;
        repeat (2) @(posedge clk);
        #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(5, LAT, "v2023");
        repeat (20) @(posedge clk);
        #1;
        check("single_done", 32'(done_cnt - d0), 32'd1);
        // Abort with clr mid-conversion.
        d0 = done_cnt;
        bcd_in = 16'h8765; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #1; clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_binary", 32'(binary), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run(16'h0042, "v0042");
        check("held_binary", 32'(binary), 32'd42);
        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
